// File: rtl/rotate_arbiter.sv
// Round-robin front end that shares one 32-bit barrel rotator between two requesters.
// One registered result stage with valid/ready handshakes and per-requester completion counters.

module rotate (
  input  logic [31:0] data_i,
  input  logic [4:0]  shift_i,
  input  logic        left_i,
  output logic [31:0] data_o
);

  logic [4:0]  amt_s;
  logic [31:0] st0_s;
  logic [31:0] st1_s;
  logic [31:0] st2_s;
  logic [31:0] st3_s;
  logic [31:0] st4_s;

  // A left rotate by k is a right rotate by (32-k) mod 32, so only right stages are built.
  always_comb begin
    amt_s  = left_i ? (5'd0 - shift_i) : shift_i;
    st0_s  = amt_s[0] ? {data_i[0],     data_i[31:1]}  : data_i;
    st1_s  = amt_s[1] ? {st0_s[1:0],    st0_s[31:2]}   : st0_s;
    st2_s  = amt_s[2] ? {st1_s[3:0],    st1_s[31:4]}   : st1_s;
    st3_s  = amt_s[3] ? {st2_s[7:0],    st2_s[31:8]}   : st2_s;
    st4_s  = amt_s[4] ? {st3_s[15:0],   st3_s[31:16]}  : st3_s;
    data_o = st4_s;
  end

endmodule

module rotate_arbiter #(
  parameter int   CNT_W   = 16,
  parameter logic RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shift,
  input  logic             req0_left,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shift,
  input  logic             req1_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q,  out_data_d;
  logic             out_id_q,    out_id_d;
  logic             ptr_q,       ptr_d;
  logic [CNT_W-1:0] cnt0_q,      cnt0_d;
  logic [CNT_W-1:0] cnt1_q,      cnt1_d;

  logic        slot_free_s;
  logic        grant_vld_s;
  logic        grant_id_s;
  logic        accept_s;
  logic        consume_s;
  logic [31:0] rot_data_s;
  logic [4:0]  rot_shift_s;
  logic        rot_left_s;
  logic [31:0] rot_res_s;

  // Grant: contested requests go to the pointer, an uncontested one wins outright.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ptr_q;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  assign slot_free_s = !out_valid_q || out_ready;
  assign accept_s    = grant_vld_s && slot_free_s;
  assign consume_s   = out_valid_q && out_ready;

  // rst_n gating keeps both readies low for the whole reset window.
  assign req0_ready  = rst_n && slot_free_s && grant_vld_s && (grant_id_s == 1'b0);
  assign req1_ready  = rst_n && slot_free_s && grant_vld_s && (grant_id_s == 1'b1);

  assign rot_data_s  = grant_id_s ? req1_data  : req0_data;
  assign rot_shift_s = grant_id_s ? req1_shift : req0_shift;
  assign rot_left_s  = grant_id_s ? req1_left  : req0_left;

  rotate u_rotate (
    .data_i  (rot_data_s),
    .shift_i (rot_shift_s),
    .left_i  (rot_left_s),
    .data_o  (rot_res_s)
  );

  // Next state: a new accept overrides a drain, so drain+accept never leaves a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_res_s;
      out_id_d    = grant_id_s;
      ptr_d       = ~grant_id_s;
    end else if (consume_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (consume_s) begin
      if (out_id_q) begin
        cnt1_d = cnt1_q + CNT_ONE;
      end else begin
        cnt0_d = cnt0_q + CNT_ONE;
      end
    end else begin
      cnt0_d = cnt0_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_id_q    <= 1'b0;
      ptr_q       <= RR_INIT;
      cnt0_q      <= {CNT_W{1'b0}};
      cnt1_q      <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter (CNT_W=4 so counter wrap is reachable quickly).

module tb_rotate_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_left;
  logic [31:0] req0_data;
  logic [4:0]  req0_shift;
  logic        req1_valid, req1_ready, req1_left;
  logic [31:0] req1_data;
  logic [4:0]  req1_shift;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_data;
  logic [3:0]  cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rotate_arbiter #(.CNT_W(4), .RR_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shift (req0_shift),
    .req0_left  (req0_left),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shift (req1_shift),
    .req1_left  (req1_left),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] d, input logic [4:0] s, input logic l);
    req0_valid = v; req0_data = d; req0_shift = s; req0_left = l;
  endtask

  task automatic set1(input logic v, input logic [31:0] d, input logic [4:0] s, input logic l);
    req1_valid = v; req1_data = d; req1_shift = s; req1_left = l;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    set0(1'b1, 32'h1111_1111, 5'd1, 1'b0);
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_data",   out_data,            32'h0);
    chk("rst_id",     {31'd0, out_id},     32'd0);
    chk("rst_cnt0",   {28'd0, cnt0},       32'd0);
    chk("rst_cnt1",   {28'd0, cnt1},       32'd0);
    tick();
    tick();
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // T1: req0 right rotate
    out_ready = 1'b1;
    set0(1'b1, 32'h1234_5678, 5'd4, 1'b0);
    #1;
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data",  out_data,           32'h8123_4567);
    chk("t1_id",    {31'd0, out_id},    32'd0);
    chk("t1_cnt0_pre", {28'd0, cnt0},   32'd0);
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t1_cnt0",  {28'd0, cnt0},      32'd1);
    chk("t1_drain", {31'd0, out_valid}, 32'd0);
    chk("t1_hold",  out_data,           32'h8123_4567);

    // T2: req1 left rotates and edge shifts
    set1(1'b1, 32'h1234_5678, 5'd4, 1'b1);
    tick();
    chk("t2_left4", out_data,        32'h2345_6781);
    chk("t2_id",    {31'd0, out_id}, 32'd1);
    set1(1'b1, 32'h1234_5678, 5'd0, 1'b1);
    tick();
    chk("t2_l0", out_data, 32'h1234_5678);
    set1(1'b1, 32'h1234_5678, 5'd0, 1'b0);
    tick();
    chk("t2_r0", out_data, 32'h1234_5678);
    set1(1'b1, 32'h8000_0000, 5'd31, 1'b1);
    tick();
    chk("t2_l31", out_data, 32'h4000_0000);
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t2_cnt1", {28'd0, cnt1}, 32'd4);
    chk("t2_cnt0", {28'd0, cnt0}, 32'd1);

    // T3: both valid, strict alternation starting at requester 0
    set0(1'b1, 32'h0000_00F0, 5'd4, 1'b0);
    set1(1'b1, 32'h0000_000F, 5'd4, 1'b1);
    #1;
    chk("t3_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t3_ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_id",    {31'd0, out_id},    (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t3_data",  out_data,           (i % 2 == 0) ? 32'h0000_000F : 32'h0000_00F0);
    end
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t3_cnt0", {28'd0, cnt0}, 32'd3);
    chk("t3_cnt1", {28'd0, cnt1}, 32'd6);

    // T4: backpressure, then drain+accept on the same edge
    out_ready = 1'b0;
    set0(1'b1, 32'hDEAD_BEEF, 5'd8, 1'b0);
    tick();
    chk("t4_data0", out_data, 32'hEFDE_ADBE);
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    set1(1'b1, 32'h0000_0001, 5'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("t4_bp_ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      chk("t4_bp_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_bp_data",  out_data,           32'hEFDE_ADBE);
      chk("t4_bp_id",    {31'd0, out_id},    32'd0);
    end
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    set0(1'b1, 32'h0000_0001, 5'd1, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("t4_da_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    chk("t4_da_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_da_data",  out_data,           32'h8000_0000);
    chk("t4_da_cnt0",  {28'd0, cnt0},      32'd4);
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t4_cnt0", {28'd0, cnt0}, 32'd5);

    // T5: 16 req0 results, counter wraps through 15 -> 0
    for (int k = 1; k <= 16; k++) begin
      set0(1'b1, k, 5'd0, 1'b0);
      tick();
      chk("t5_data", out_data, k);
      chk("t5_cnt0", {28'd0, cnt0}, (5 + k - 1) % 16);
    end
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t5_cnt0_end", {28'd0, cnt0}, 32'd5);
    chk("t5_cnt1",     {28'd0, cnt1}, 32'd6);

    // T6: async reset while a result is held under backpressure
    out_ready = 1'b0;
    set0(1'b1, 32'hCAFE_F00D, 5'd0, 1'b1);
    tick();
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, out_valid},  32'd0);
    chk("t6_data",  out_data,            32'h0);
    chk("t6_cnt0",  {28'd0, cnt0},       32'd0);
    chk("t6_cnt1",  {28'd0, cnt1},       32'd0);
    chk("t6_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    set0(1'b0, 32'h0, 5'd0, 1'b0);
    set1(1'b1, 32'h1234_5678, 5'd8, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("t6_id1",   {31'd0, out_id}, 32'd1);
    chk("t6_data1", out_data,        32'h7812_3456);
    set1(1'b1, 32'h0000_FFFF, 5'd16, 1'b1);
    tick();
    chk("t6_id2",   {31'd0, out_id}, 32'd1);
    chk("t6_data2", out_data,        32'hFFFF_0000);
    set1(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t6_cnt1_end", {28'd0, cnt1}, 32'd2);
    chk("t6_cnt0_end", {28'd0, cnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
